// File: rtl/dram_port_arbiter.sv
// rtl/dram_port_arbiter.sv - three-port DRAM arbiter with starvation guard for the fetch port
module dram_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        RST_X,
    input  logic [2:0]  w_req,
    input  logic [95:0] w_addr,
    input  logic [95:0] w_wdata,
    input  logic [2:0]  w_we,
    input  logic [8:0]  w_ctrl,
    output logic [2:0]  w_gnt,
    output logic [2:0]  w_done,
    output logic [31:0] w_rdata,
    output logic [31:0] w_dram_addr,
    output logic [31:0] w_dram_wdata,
    output logic [2:0]  w_dram_ctrl,
    output logic        w_dram_we,
    output logic        w_dram_le,
    input  logic [31:0] w_dram_odata,
    input  logic        w_dram_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic [1:0]  owner_q, owner_d;
    logic        lat_we_q, lat_we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  gnt_q, gnt_d;
    logic [2:0]  done_q, done_d;
    logic        dwe_q, dwe_d;
    logic        dle_q, dle_d;

    logic [31:0] addr_a  [0:2];
    logic [31:0] wdata_a [0:2];
    logic [2:0]  ctrl_a  [0:2];
    logic [1:0]  win;

    // Unpack the per-port payload buses into indexable arrays
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            addr_a[i]  = w_addr[i*32 +: 32];
            wdata_a[i] = w_wdata[i*32 +: 32];
            ctrl_a[i]  = w_ctrl[i*3 +: 3];
        end
    end

    // Fixed priority 0>1>2, overridden in favour of port 2 once it has waited too long
    always_comb begin
        win = 2'd0;
        if (w_req[2] && (starve_q == STARVE_LIM)) begin
            win = 2'd2;
        end else if (w_req[0]) begin
            win = 2'd0;
        end else if (w_req[1]) begin
            win = 2'd1;
        end else if (w_req[2]) begin
            win = 2'd2;
        end
    end

    // Next-state logic; registered outputs are derived from the next state so
    // they line up exactly with the state they describe
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        owner_d  = owner_q;
        lat_we_d = lat_we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ctrl_d   = ctrl_q;
        rdata_d  = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (!w_req[2]) begin
                    starve_d = 4'd0;
                end
                if ((|w_req) && !w_dram_busy) begin
                    state_d  = S_ISSUE;
                    owner_d  = win;
                    lat_we_d = w_we[win];
                    addr_d   = addr_a[win];
                    wdata_d  = wdata_a[win];
                    ctrl_d   = ctrl_a[win];
                    if (win == 2'd2) begin
                        starve_d = 4'd0;
                    end else if (w_req[2] && (starve_q != STARVE_LIM)) begin
                        starve_d = starve_q + 4'd1;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!w_dram_busy) begin
                    state_d = S_DONE;
                    if (!lat_we_q) begin
                        rdata_d = w_dram_odata;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        gnt_d  = (state_d != S_IDLE) ? (3'b001 << owner_d) : 3'b000;
        done_d = (state_d == S_DONE) ? (3'b001 << owner_d) : 3'b000;
        dwe_d  = (state_d == S_ISSUE) && lat_we_d;
        dle_d  = (state_d == S_ISSUE) && !lat_we_d;
    end

    // State and output registers; reset abandons any transaction in flight
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q  <= S_IDLE;
            starve_q <= 4'd0;
            owner_q  <= 2'd0;
            lat_we_q <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            ctrl_q   <= 3'd0;
            rdata_q  <= 32'd0;
            gnt_q    <= 3'd0;
            done_q   <= 3'd0;
            dwe_q    <= 1'b0;
            dle_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            owner_q  <= owner_d;
            lat_we_q <= lat_we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ctrl_q   <= ctrl_d;
            rdata_q  <= rdata_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            dwe_q    <= dwe_d;
            dle_q    <= dle_d;
        end
    end

    assign w_gnt        = gnt_q;
    assign w_done       = done_q;
    assign w_rdata      = rdata_q;
    assign w_dram_addr  = addr_q;
    assign w_dram_wdata = wdata_q;
    assign w_dram_ctrl  = ctrl_q;
    assign w_dram_we    = dwe_q;
    assign w_dram_le    = dle_q;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb/tb_dram_port_arbiter.sv - vector-table bench for dram_port_arbiter
module tb_dram_port_arbiter;

    logic        CLK = 1'b0;
    logic        RST_X;
    logic [2:0]  w_req;
    logic [95:0] w_addr;
    logic [95:0] w_wdata;
    logic [2:0]  w_we;
    logic [8:0]  w_ctrl;
    logic [2:0]  w_gnt;
    logic [2:0]  w_done;
    logic [31:0] w_rdata;
    logic [31:0] w_dram_addr;
    logic [31:0] w_dram_wdata;
    logic [2:0]  w_dram_ctrl;
    logic        w_dram_we;
    logic        w_dram_le;
    logic [31:0] w_dram_odata;
    logic        w_dram_busy;

    dram_port_arbiter #(.STARVE_MAX(4)) dut (
        .CLK          (CLK),
        .RST_X        (RST_X),
        .w_req        (w_req),
        .w_addr       (w_addr),
        .w_wdata      (w_wdata),
        .w_we         (w_we),
        .w_ctrl       (w_ctrl),
        .w_gnt        (w_gnt),
        .w_done       (w_done),
        .w_rdata      (w_rdata),
        .w_dram_addr  (w_dram_addr),
        .w_dram_wdata (w_dram_wdata),
        .w_dram_ctrl  (w_dram_ctrl),
        .w_dram_we    (w_dram_we),
        .w_dram_le    (w_dram_le),
        .w_dram_odata (w_dram_odata),
        .w_dram_busy  (w_dram_busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]   req;
        logic [2:0]   we;
        logic         busy;
        logic [31:0]  od;
        logic [106:0] exp;
    } vec_t;

    vec_t        vq[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] pa [0:3];
    logic [31:0] pw [0:3];
    logic [2:0]  pc [0:3];
    logic [31:0] exp_rd;

    localparam logic [31:0] R0 = 32'h0A0A_0001;
    localparam logic [31:0] R1 = 32'h0A0A_0002;
    localparam logic [31:0] R2 = 32'h0A0A_0003;
    localparam logic [31:0] R3 = 32'h0000_3333;

    // lp selects which port's payload should sit on the DRAM side; 3 means all-zero
    function automatic logic [106:0] pack(input logic [2:0] g, input logic [2:0] d,
                                          input logic e, input logic l,
                                          input logic [31:0] rd, input int lp);
        return {g, d, e, l, rd, pa[lp], pw[lp], pc[lp]};
    endfunction

    function automatic vec_t mk(input logic [2:0] req, input logic [2:0] we, input logic busy,
                                input logic [31:0] od, input logic [2:0] g, input logic [2:0] d,
                                input logic e, input logic l, input logic [31:0] rd, input int lp);
        vec_t v;
        v.req = req; v.we = we; v.busy = busy; v.od = od;
        v.exp = pack(g, d, e, l, rd, lp);
        return v;
    endfunction

    function automatic string fmt(input logic [106:0] x);
        return $sformatf("gnt=%b done=%b we=%b le=%b rdata=%h addr=%h wdata=%h ctrl=%b",
                         x[106:104], x[103:101], x[100], x[99], x[98:67], x[66:35], x[34:3], x[2:0]);
    endfunction

    task automatic chk(input string name, input logic [106:0] exp);
        logic [106:0] got;
        got = {w_gnt, w_done, w_dram_we, w_dram_le, w_rdata, w_dram_addr, w_dram_wdata, w_dram_ctrl};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %s ; want %s", name, fmt(got), fmt(exp));
        end
    endtask

    task automatic step(input vec_t v, input string name);
        @(negedge CLK);
        w_req        = v.req;
        w_we         = v.we;
        w_dram_busy  = v.busy;
        w_dram_odata = v.od;
        @(posedge CLK);
        #1;
        chk(name, v.exp);
    endtask

    // One zero-wait read transaction with port 0 and port 2 both requesting
    task automatic run_txn(input int p, input logic [31:0] od, input int n);
        logic [2:0] g;
        g = 3'b001 << p;
        step(mk(3'b101, 3'b000, 1'b0, 32'h0, g, 3'b000, 1'b0, 1'b1, exp_rd, p), $sformatf("starve%0d_issue", n));
        step(mk(3'b101, 3'b000, 1'b0, 32'h0, g, 3'b000, 1'b0, 1'b0, exp_rd, p), $sformatf("starve%0d_wait", n));
        exp_rd = od;
        step(mk(3'b101, 3'b000, 1'b0, od, g, g, 1'b0, 1'b0, exp_rd, p), $sformatf("starve%0d_done", n));
        step(mk(3'b101, 3'b000, 1'b0, 32'h0, 3'b000, 3'b000, 1'b0, 1'b0, exp_rd, p), $sformatf("starve%0d_idle", n));
    endtask

    initial begin
        pa[0] = 32'h1000_0000; pa[1] = 32'h8000_1000; pa[2] = 32'h2000_0200; pa[3] = 32'h0;
        pw[0] = 32'h0000_00A5; pw[1] = 32'h1234_5678; pw[2] = 32'hCAFE_0002; pw[3] = 32'h0;
        pc[0] = 3'b000;        pc[1] = 3'b010;        pc[2] = 3'b100;        pc[3] = 3'b000;
        w_addr       = {pa[2], pa[1], pa[0]};
        w_wdata      = {pw[2], pw[1], pw[0]};
        w_ctrl       = {pc[2], pc[1], pc[0]};
        w_req        = 3'b000;
        w_we         = 3'b000;
        w_dram_busy  = 1'b0;
        w_dram_odata = 32'h0;
        RST_X        = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset", pack(3'b000, 3'b000, 1'b0, 1'b0, 32'h0, 3));
        @(negedge CLK);
        RST_X = 1'b1;

        // single read on port 1, DRAM busy three cycles
        vq.push_back(mk(3'b010, 3'b000, 1'b0, 32'h0,        3'b010, 3'b000, 1'b0, 1'b1, 32'h0, 1));
        vq.push_back(mk(3'b010, 3'b000, 1'b0, 32'h0,        3'b010, 3'b000, 1'b0, 1'b0, 32'h0, 1));
        vq.push_back(mk(3'b010, 3'b000, 1'b1, 32'h0,        3'b010, 3'b000, 1'b0, 1'b0, 32'h0, 1));
        vq.push_back(mk(3'b010, 3'b000, 1'b1, 32'h0,        3'b010, 3'b000, 1'b0, 1'b0, 32'h0, 1));
        vq.push_back(mk(3'b010, 3'b000, 1'b1, 32'h0,        3'b010, 3'b000, 1'b0, 1'b0, 32'h0, 1));
        vq.push_back(mk(3'b010, 3'b000, 1'b0, 32'hDEADBEEF, 3'b010, 3'b010, 1'b0, 1'b0, 32'hDEADBEEF, 1));
        vq.push_back(mk(3'b000, 3'b000, 1'b0, 32'h0,        3'b000, 3'b000, 1'b0, 1'b0, 32'hDEADBEEF, 1));
        vq.push_back(mk(3'b000, 3'b000, 1'b0, 32'h0,        3'b000, 3'b000, 1'b0, 1'b0, 32'hDEADBEEF, 1));
        // all three request together: served 0, 1, 2
        vq.push_back(mk(3'b111, 3'b000, 1'b0, 32'h0, 3'b001, 3'b000, 1'b0, 1'b1, 32'hDEADBEEF, 0));
        vq.push_back(mk(3'b111, 3'b000, 1'b0, 32'h0, 3'b001, 3'b000, 1'b0, 1'b0, 32'hDEADBEEF, 0));
        vq.push_back(mk(3'b111, 3'b000, 1'b1, 32'h0, 3'b001, 3'b000, 1'b0, 1'b0, 32'hDEADBEEF, 0));
        vq.push_back(mk(3'b111, 3'b000, 1'b0, R0,    3'b001, 3'b001, 1'b0, 1'b0, R0, 0));
        vq.push_back(mk(3'b110, 3'b000, 1'b0, 32'h0, 3'b000, 3'b000, 1'b0, 1'b0, R0, 0));
        vq.push_back(mk(3'b110, 3'b000, 1'b0, 32'h0, 3'b010, 3'b000, 1'b0, 1'b1, R0, 1));
        vq.push_back(mk(3'b110, 3'b000, 1'b0, 32'h0, 3'b010, 3'b000, 1'b0, 1'b0, R0, 1));
        vq.push_back(mk(3'b110, 3'b000, 1'b1, 32'h0, 3'b010, 3'b000, 1'b0, 1'b0, R0, 1));
        vq.push_back(mk(3'b110, 3'b000, 1'b0, R1,    3'b010, 3'b010, 1'b0, 1'b0, R1, 1));
        vq.push_back(mk(3'b100, 3'b000, 1'b0, 32'h0, 3'b000, 3'b000, 1'b0, 1'b0, R1, 1));
        vq.push_back(mk(3'b100, 3'b000, 1'b0, 32'h0, 3'b100, 3'b000, 1'b0, 1'b1, R1, 2));
        vq.push_back(mk(3'b100, 3'b000, 1'b0, 32'h0, 3'b100, 3'b000, 1'b0, 1'b0, R1, 2));
        vq.push_back(mk(3'b100, 3'b000, 1'b1, 32'h0, 3'b100, 3'b000, 1'b0, 1'b0, R1, 2));
        vq.push_back(mk(3'b100, 3'b000, 1'b0, R2,    3'b100, 3'b100, 1'b0, 1'b0, R2, 2));
        vq.push_back(mk(3'b000, 3'b000, 1'b0, 32'h0, 3'b000, 3'b000, 1'b0, 1'b0, R2, 2));
        // write on port 1 (SW): write strobe only, read data untouched
        vq.push_back(mk(3'b010, 3'b010, 1'b0, 32'h0,        3'b010, 3'b000, 1'b1, 1'b0, R2, 1));
        vq.push_back(mk(3'b010, 3'b010, 1'b0, 32'h0,        3'b010, 3'b000, 1'b0, 1'b0, R2, 1));
        vq.push_back(mk(3'b010, 3'b010, 1'b1, 32'h0,        3'b010, 3'b000, 1'b0, 1'b0, R2, 1));
        vq.push_back(mk(3'b010, 3'b010, 1'b0, 32'hBAD0BAD0, 3'b010, 3'b010, 1'b0, 1'b0, R2, 1));
        vq.push_back(mk(3'b000, 3'b000, 1'b0, 32'h0,        3'b000, 3'b000, 1'b0, 1'b0, R2, 1));
        // DRAM busy in IDLE holds off the grant; request dropped mid-transaction still completes
        vq.push_back(mk(3'b001, 3'b000, 1'b1, 32'h0, 3'b000, 3'b000, 1'b0, 1'b0, R2, 1));
        vq.push_back(mk(3'b001, 3'b000, 1'b1, 32'h0, 3'b000, 3'b000, 1'b0, 1'b0, R2, 1));
        vq.push_back(mk(3'b001, 3'b000, 1'b1, 32'h0, 3'b000, 3'b000, 1'b0, 1'b0, R2, 1));
        vq.push_back(mk(3'b001, 3'b000, 1'b0, 32'h0, 3'b001, 3'b000, 1'b0, 1'b1, R2, 0));
        vq.push_back(mk(3'b000, 3'b000, 1'b0, 32'h0, 3'b001, 3'b000, 1'b0, 1'b0, R2, 0));
        vq.push_back(mk(3'b000, 3'b000, 1'b1, 32'h0, 3'b001, 3'b000, 1'b0, 1'b0, R2, 0));
        vq.push_back(mk(3'b000, 3'b000, 1'b0, R3,    3'b001, 3'b001, 1'b0, 1'b0, R3, 0));
        vq.push_back(mk(3'b000, 3'b000, 1'b0, 32'h0, 3'b000, 3'b000, 1'b0, 1'b0, R3, 0));

        foreach (vq[i]) begin
            step(vq[i], $sformatf("vec%0d", i));
        end

        // starvation guard: four port-0 grants, then port 2, repeated twice
        exp_rd = R3;
        for (int n = 0; n < 10; n++) begin
            run_txn(((n % 5) == 4) ? 2 : 0, 32'h5000_0000 + 32'(n), n);
        end

        // reset during WAIT abandons the transaction, then the request is re-arbitrated
        step(mk(3'b010, 3'b000, 1'b0, 32'h0, 3'b010, 3'b000, 1'b0, 1'b1, exp_rd, 1), "rst_issue");
        step(mk(3'b010, 3'b000, 1'b1, 32'h0, 3'b010, 3'b000, 1'b0, 1'b0, exp_rd, 1), "rst_wait0");
        step(mk(3'b010, 3'b000, 1'b1, 32'h0, 3'b010, 3'b000, 1'b0, 1'b0, exp_rd, 1), "rst_wait1");
        @(negedge CLK);
        RST_X = 1'b0;
        #1;
        chk("rst_async", pack(3'b000, 3'b000, 1'b0, 1'b0, 32'h0, 3));
        @(posedge CLK);
        #1;
        chk("rst_hold", pack(3'b000, 3'b000, 1'b0, 1'b0, 32'h0, 3));
        @(negedge CLK);
        RST_X = 1'b1;
        @(posedge CLK);
        #1;
        chk("rst_release_busy", pack(3'b000, 3'b000, 1'b0, 1'b0, 32'h0, 3));
        step(mk(3'b010, 3'b000, 1'b0, 32'h0,        3'b010, 3'b000, 1'b0, 1'b1, 32'h0, 1), "rearb_issue");
        step(mk(3'b010, 3'b000, 1'b0, 32'h0,        3'b010, 3'b000, 1'b0, 1'b0, 32'h0, 1), "rearb_wait");
        step(mk(3'b010, 3'b000, 1'b0, 32'h7777_0000, 3'b010, 3'b010, 1'b0, 1'b0, 32'h7777_0000, 1), "rearb_done");
        step(mk(3'b000, 3'b000, 1'b0, 32'h0,        3'b000, 3'b000, 1'b0, 1'b0, 32'h7777_0000, 1), "rearb_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
